// File: rtl/shared_reg_arb_pkg.sv
// Shared types and defaults for the shared-register arbiter.
// Pure declarations: no latency and no flow control of its own.
package shared_reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set req at or after ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to use idx.
module rr_priority_picker #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            any,
   output logic [IDW-1:0]  idx
);

   logic [2*NREQ-1:0] w_dbl;
   logic [IDW:0]      w_pos;
   logic [IDW:0]      w_wrap;

   assign w_dbl = {req, req};
   assign any   = |req;

   // Scan downward so the closest set bit after ptr is the last one written.
   always_comb begin
      w_pos  = '0;
      w_wrap = '0;
      idx    = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         w_pos = {1'b0, ptr} + (IDW + 1)'(j);
         if (w_dbl[w_pos]) begin
            w_wrap = (w_pos >= (IDW + 1)'(NREQ)) ? w_pos - (IDW + 1)'(NREQ) : w_pos;
            idx    = IDW'(w_wrap);
         end
      end
   end

endmodule

// File: rtl/shared_register_arbiter.sv
// Round-robin load sequencer for one shared register: IDLE grant, LOAD, one-cycle ACK.
// Three cycles per write; requesters hold req/data until their ack pulse.
module shared_register_arbiter
   import shared_reg_arb_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data_in,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      reg_out,
   output logic [IDW-1:0]        owner,
   output logic                  owner_valid,
   output logic                  busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_grant;
   logic [IDW-1:0]   r_owner;
   logic             r_owner_valid;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] w_word;
   logic [IDW-1:0]   w_pick;
   logic             w_any;
   logic             w_grab;
   logic             w_ld;
   logic             w_ack_st;

   rr_priority_picker #(.NREQ(NREQ)) u_picker (
      .req (req),
      .ptr (r_ptr),
      .any (w_any),
      .idx (w_pick)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = IDLE;
      w_grab      = 1'b0;
      w_ld        = 1'b0;
      w_ack_st    = 1'b0;
      case (r_state)
         IDLE: begin
            w_grab = w_any;
            if (w_any) w_state_nxt = LOAD;
         end
         LOAD: begin
            w_ld        = 1'b1;
            w_state_nxt = ACK;
         end
         ACK: begin
            w_ack_st    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_word = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant == IDW'(i)) w_word = data_in[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr         <= '0;
         r_grant       <= '0;
         r_reg         <= '0;
         r_owner       <= '0;
         r_owner_valid <= 1'b0;
      end else begin
         if (w_grab) r_grant <= w_pick;
         if (w_ld)   r_reg   <= w_word;
         if (w_ack_st) begin
            r_owner       <= r_grant;
            r_owner_valid <= 1'b1;
            r_ptr         <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
         end
      end
   end

   assign ack         = w_ack_st ? (NREQ'(1) << r_grant) : '0;
   assign busy        = w_ld | w_ack_st;
   assign reg_out     = r_reg;
   assign owner       = r_owner;
   assign owner_valid = r_owner_valid;

endmodule

// File: tb/tb_shared_register_arbiter.sv
// Bench for shared_register_arbiter: a transaction-level model predicts each write,
// a scoreboard queue holds the expected acks and a negedge monitor compares them.
module tb_shared_register_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] data_in = '0;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      reg_out;
   logic [1:0]            owner;
   logic                  owner_valid;
   logic                  busy;

   shared_register_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .data_in     (data_in),
      .ack         (ack),
      .reg_out     (reg_out),
      .owner       (owner),
      .owner_valid (owner_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int edge_cnt = 0;

   typedef struct {
      int         due;
      int         grant;
      logic [15:0] word;
   } exp_t;
   exp_t exp_q[$];

   // Reference model: a write is "waiting", "loading" or "acking"; grant is the
   // nearest requester at or after the rotating pointer.
   int          m_phase = 0;
   int          m_ptr   = 0;
   int          m_grant = 0;
   int          m_owner = 0;
   logic        m_valid = 1'b0;
   logic [15:0] m_reg   = '0;
   bit          m_found;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   always @(posedge clk) begin
      edge_cnt++;
      if (!rst) begin
         m_phase = 0;
         m_ptr   = 0;
         m_reg   = '0;
         m_owner = 0;
         m_valid = 1'b0;
         exp_q.delete();
      end else if (m_phase == 0) begin
         if (req != '0) begin
            m_found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
               if (!m_found && req[(m_ptr + k) % NREQ]) begin
                  m_grant = (m_ptr + k) % NREQ;
                  m_found = 1'b1;
               end
            end
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_reg = data_in[m_grant*WIDTH +: WIDTH];
         exp_q.push_back('{edge_cnt, m_grant, m_reg});
         m_phase = 2;
      end else begin
         m_owner = m_grant;
         m_valid = 1'b1;
         m_ptr   = (m_grant + 1) % NREQ;
         m_phase = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (edge_cnt > 0) begin
         check("busy", busy, (m_phase != 0));
         check("reg_out", reg_out, m_reg);
         check("owner", owner, m_owner);
         check("owner_valid", owner_valid, m_valid);
         if (ack !== '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ack", ack, 0);
            end else begin
               e = exp_q.pop_front();
               check("ack_cycle", edge_cnt, e.due);
               check("ack_onehot", ack, 32'd1 << e.grant);
               check("ack_word", reg_out, e.word);
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
            e = exp_q.pop_front();
            check("missing_ack", ack, 32'd1 << e.grant);
         end
      end
   end

   task automatic wait_ack(input bit drop, output int idx);
      idx = -1;
      for (int t = 0; t < 20 && idx < 0; t++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) idx = i;
      end
      if (idx < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL ack_timeout: no ack within 20 cycles, req=%b", req);
      end else if (drop) begin
         req[idx] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int idx;
      int last_edge;

      // Reset held with random requests
      req = 4'($urandom);
      repeat (2) begin
         @(negedge clk);
         req = 4'($urandom);
      end
      check("rst_reg_out", reg_out, 0);
      check("rst_ack", ack, 0);
      check("rst_owner_valid", owner_valid, 0);
      check("rst_busy", busy, 0);
      req = '0;
      rst = 1'b1;
      @(negedge clk);

      // Single requester
      data_in[2*WIDTH +: WIDTH] = 16'hAAAA;
      req = 4'b0100;
      wait_ack(1'b1, idx);
      check("single_idx", idx, 2);
      check("single_word", reg_out, 16'hAAAA);
      @(negedge clk);
      check("single_owner", owner, 2);
      check("single_valid", owner_valid, 1);

      // Round-robin with everyone requesting
      do_reset();
      for (int i = 0; i < NREQ; i++) data_in[i*WIDTH +: WIDTH] = 16'h1111 * 16'(i + 1);
      req = 4'b1111;
      last_edge = 0;
      for (int n = 0; n < 5; n++) begin
         wait_ack(1'b0, idx);
         check("rr_order", idx, n % NREQ);
         check("rr_word", reg_out, 16'h1111 * 16'((n % NREQ) + 1));
         if (n > 0) check("rr_spacing", edge_cnt - last_edge, 3);
         last_edge = edge_cnt;
      end
      req = '0;

      // Wrap: after owner 3, pointer returns to 0
      req = 4'b1000;
      wait_ack(1'b1, idx);
      check("wrap_first", idx, 3);
      req = 4'b1001;
      wait_ack(1'b0, idx);
      check("wrap_to_0", idx, 0);
      wait_ack(1'b1, idx);
      check("wrap_then_3", idx, 3);
      req = '0;
      repeat (3) @(negedge clk);

      // Request dropped during LOAD still completes
      data_in[1*WIDTH +: WIDTH] = 16'h5A5A;
      req = 4'b0010;
      @(negedge clk);
      req = '0;
      wait_ack(1'b1, idx);
      check("drop_idx", idx, 1);
      check("drop_word", reg_out, 16'h5A5A);
      repeat (2) @(negedge clk);

      // Reset in the LOAD cycle aborts the write and rewinds the pointer
      data_in[1*WIDTH +: WIDTH] = 16'hBEEF;
      req = 4'b0010;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ack", ack, 0);
      check("midrst_reg", reg_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_valid", owner_valid, 0);
      rst = 1'b1;
      req = 4'b1001;
      wait_ack(1'b1, idx);
      check("midrst_restart", idx, 0);
      req = '0;
      repeat (3) @(negedge clk);

      // Random traffic against the model
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i] === 1'b1) begin
               if ($urandom_range(3) != 0) req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom_range(4) == 0) begin
                  data_in[i*WIDTH +: WIDTH] = 16'($urandom);
                  req[i] = 1'b1;
               end
            end else if ($urandom_range(31) == 0) begin
               req[i] = 1'b0;
            end
         end
      end
      req = '0;
      repeat (8) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
